sag_rr_sched: RTL

- Round-robin scheduler that shares one 32-bit sheep-and-goats permutation core (SAG4Fun32c) among NREQ requesters.
- Owns the single core instance and registers operands in front of it and the result behind it.
- Returns each result to the requester that issued it over a valid/ready handshake.
- Sits between the bit-manipulation issue logic of several clients and the shared permutation datapath.

---
 rtl/sag_rr_sched_if.sv | 32 +++
 rtl/sag_rr_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sag_rr_sched_if.sv
// Request/response bundle between NREQ clients and the shared
// sheep-and-goats scheduler. Requester i owns bits [32*i+31:32*i] of the
// packed data/mask buses and bit i of every per-requester vector.
interface sag_rr_sched_if #(
    parameter int NREQ = 2
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_inv;
    logic [NREQ-1:0]    req_msk;
    logic [32*NREQ-1:0] req_data;
    logic [32*NREQ-1:0] req_mask;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [31:0]        rsp_data;
    logic               busy;
    logic [IW-1:0]      grant_id;

    // client side
    modport master (
        output req_valid, req_inv, req_msk, req_data, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy, grant_id
    );

    // scheduler side
    modport slave (
        input  req_valid, req_inv, req_msk, req_data, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy, grant_id
    );
endinterface

// File: rtl/sag_rr_sched.sv
// Round-robin front end for a single 32-bit sheep-and-goats permutation core.
// Operands are registered in front of the core, the result behind it, and the
// result is handed back to the issuing requester over valid/ready.
//
// Core behaviour: bits of data whose (optionally inverted) mask bit is 1 are
// packed toward bit 0 in ascending order; bits whose mask bit is 0 are packed
// toward bit 31, the lowest such bit landing in bit 31. ctrl_inv complements
// the mask before use; ctrl_msk zeroes the mask-0 field instead of filling it.
//
// state | meaning
// IDLE  | no operation in flight, a grant may be taken
// EXEC  | core evaluating the latched operands (exactly one cycle)
// RESP  | result presented to the owner, waiting for its rsp_ready
module sag_rr_sched #(
    parameter int NREQ = 2
) (
    input  logic          clk,
    input  logic          reset,
    sag_rr_sched_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   grant_id_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic            busy_q;

    logic            op_inv_q;
    logic            op_msk_q;
    logic [31:0]     op_data_q;
    logic [31:0]     op_mask_q;

    logic [IW-1:0]   grant_sel;
    logic            grant_found;
    logic            owner_ready;
    logic            can_take;
    logic            accept;

    logic [31:0]     eff_mask;
    logic [31:0]     core_out;
    logic [4:0]      lo;
    logic [4:0]      hi;

    // Rotating-priority search: first valid requester after the last winner.
    always_comb begin
        grant_sel   = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && bus.req_valid[i] && (((int'(last_q) + k) % NREQ) == i)) begin
                    grant_found = 1'b1;
                    grant_sel   = IW'(i);
                end
            end
        end
    end

    // rsp_valid_q is one-hot on the owner while in RESP, so this picks out
    // only the owner's rsp_ready and ignores everyone else's.
    assign owner_ready = |(bus.rsp_ready & rsp_valid_q);
    assign can_take    = (state_q == IDLE) || ((state_q == RESP) && owner_ready);
    assign accept      = can_take && grant_found;

    assign bus.req_ready = accept ? (NREQ'(1) << grant_sel) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_id_q;

    // Sheep-and-goats core fed straight from the operand registers.
    always_comb begin
        eff_mask = op_inv_q ? ~op_mask_q : op_mask_q;
        core_out = '0;
        lo       = '0;
        hi       = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (eff_mask[i]) begin
                core_out[lo] = op_data_q[i];
                lo           = lo + 5'd1;
            end else begin
                if (!op_msk_q) begin
                    core_out[hi] = op_data_q[i];
                end
                hi = hi - 5'd1;
            end
        end
    end

    // Scheduler FSM with operand capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            grant_id_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_inv_q   <= bus.req_inv[grant_sel];
                        op_msk_q   <= bus.req_msk[grant_sel];
                        op_data_q  <= bus.req_data[32*grant_sel +: 32];
                        op_mask_q  <= bus.req_mask[32*grant_sel +: 32];
                        grant_id_q <= grant_sel;
                        last_q     <= grant_sel;
                        busy_q     <= 1'b1;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= core_out;
                    rsp_valid_q <= NREQ'(1) << grant_id_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        rsp_valid_q <= '0;
                        if (accept) begin
                            op_inv_q   <= bus.req_inv[grant_sel];
                            op_msk_q   <= bus.req_msk[grant_sel];
                            op_data_q  <= bus.req_data[32*grant_sel +: 32];
                            op_mask_q  <= bus.req_mask[32*grant_sel +: 32];
                            grant_id_q <= grant_sel;
                            last_q     <= grant_sel;
                            state_q    <= EXEC;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
